dma_ch_ctrl: RTL
================

# dma_ch_ctrl

Single-channel DMA transfer sequencer driven by the DMA register file. On a channel start pulse it copies the programmed command (read address, write address, buffer size, flags), moves the buffer word by word over a single-master memory port, and reports progress counters and completion interrupts back to the register file. Optionally, it walks a linked list of 16-byte commands held in memory.

## Interface
Parameters:
- none. Address and data widths are fixed at 32 bits; counters are 16 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ch_start  in  1  one-cycle start pulse (register file wr_ch_start)
- rd_start_addr  in  32  first command read byte address
- wr_start_addr  in  32  first command write byte address
- buffer_size  in  32  first command length in bytes; bits [1:0] ignored
- set_int  in  1  first command: raise irq on completion
- cmd_last  in  1  first command: last in list
- next_addr  in  28  first command: next command address bits [31:4]
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word-aligned byte address
- mem_wdata  out  32  write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data
- buffer_count  out  16  words moved in the current command
- int_count  out  16  interrupts raised since reset
- irq  out  1  one-cycle completion pulse
- busy  out  1  channel active

## Operation
- States: IDLE, CMD_RD, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, CMD_DONE.
- IDLE: on ch_start, latch the five command inputs into working registers, clear buffer_count, then go to RD_REQ. ch_start outside IDLE is ignored.
- Word count = buffer_size[31:2]. If it is zero, go straight to CMD_DONE with no memory access.
- RD_REQ: hold mem_req=1, mem_we=0, mem_addr=rd_ptr until mem_gnt, then go to RD_WAIT. RD_WAIT: on mem_rvalid, capture mem_rdata into a one-word holding register, then go to WR_REQ.
- WR_REQ: hold mem_req=1, mem_we=1, mem_addr=wr_ptr, mem_wdata=holding register until mem_gnt. On gnt: rd_ptr += 4, wr_ptr += 4, buffer_count += 1, words-remaining -= 1. If words remain, go to RD_REQ; otherwise go to CMD_DONE. WR_WAIT is reserved and unused; it falls through to RD_REQ.
- Pointer arithmetic: 32-bit, wraps modulo 2^32. buffer_count wraps modulo 2^16.
- CMD_DONE (one cycle): if set_int, pulse irq and increment int_count (wraps). If cmd_last=1, go to IDLE. Otherwise go to CMD_RD with fetch base {next_addr, 4'h0}.
- CMD_RD: four sequential reads at base+0, +4, +8, +C. Each read is req/gnt, then rvalid. Word 0 → rd_ptr. Word 1 → wr_ptr. Word 2 → size. Word 3 → set_int = bit 0, cmd_last = bit 1, next_addr = bits [31:4]. Then clear buffer_count and go to RD_REQ, applying the zero-length rule.
- At most one memory access is outstanding. mem_rvalid outside RD_WAIT/CMD_RD is ignored.
- Reset at any time returns to IDLE and clears all registers.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, buffer_count=0, int_count=0, irq=0, busy=0.
- All outputs are registered or decoded from state only; there is no combinational path from mem_* inputs to outputs.
- ch_start sampled at edge N → busy=1 and mem_req=1 from N+1.
- mem_req stays stable with its address and data until the edge where mem_gnt=1; it drops, or the next request starts, from the following cycle.
- Zero-wait memory (gnt in the request cycle, rvalid the next cycle) gives 3 cycles per word.
- busy falls in the cycle after CMD_DONE when cmd_last=1. irq is high exactly during CMD_DONE.

## Configuration
- DMA_CMD_LIST_EN defined: command-list chaining through CMD_RD as described above.
- Not defined: the CMD_RD state and fetch logic are omitted, and cmd_last is forced to 1. Every start performs exactly one command and next_addr is unused.

## Structure
- Shared package dma_pkg holds:
  - the state enum
  - descriptor word offsets (0, 4, 8, C)
  - flag bit positions (SET_INT=0, CMD_LAST=1)
  - NEXT_ADDR_LSB=4
- The register file uses the same constants.
- One natural sub-module: dma_cmd_fetch, a 4-word descriptor fetch sequencer, instantiated only under DMA_CMD_LIST_EN. The main FSM arbitrates the memory port between it and the data mover.

## Test plan
- Basic copy: rd=0x1000, wr=0x2000, size=16, set_int=1, cmd_last=1, zero-wait memory → 4 reads/4 writes; dest equals source; buffer_count=4; one irq; int_count=1; busy low after 13 cycles.
- Zero and unaligned size: size=0 → no mem_req and irq in 2 cycles. Size=7 → exactly 1 word moved.
- Backpressure: random gnt and rvalid delays of 0–5 cycles → mem_addr/we/wdata stable while mem_req is high without gnt; data intact.
- Chain (DMA_CMD_LIST_EN): first cmd_last=0, next_addr=0x0000030 → fetch at 0x300–0x30C; second command (size=8, set_int=1, cmd_last=1) executes; int_count reflects only set_int commands.
- Start while busy and mid-run reset: ch_start during the transfer is ignored. reset asserted mid-WR_REQ → next cycle all outputs 0 and state IDLE; a fresh start then works.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared DMA channel types and descriptor constants
// Purpose: FSM state encoding, 16-byte descriptor layout and flag bit
//          positions shared by the channel sequencer and the register file.
// Ports:   none (package).
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD_RD,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        CMD_DONE
    } dma_state_e;

    // Byte offsets of the four words inside a descriptor
    localparam logic [3:0] DESC_OFS_RD_PTR = 4'h0;
    localparam logic [3:0] DESC_OFS_WR_PTR = 4'h4;
    localparam logic [3:0] DESC_OFS_SIZE   = 4'h8;
    localparam logic [3:0] DESC_OFS_FLAGS  = 4'hC;

    // Bit positions inside the descriptor flags word
    localparam int FLAG_SET_INT   = 0;
    localparam int FLAG_CMD_LAST  = 1;
    localparam int NEXT_ADDR_LSB  = 4;

    function automatic logic [3:0] desc_offset(input logic [1:0] idx);
        logic [3:0] ofs;
        case (idx)
            2'd0:    ofs = DESC_OFS_RD_PTR;
            2'd1:    ofs = DESC_OFS_WR_PTR;
            2'd2:    ofs = DESC_OFS_SIZE;
            default: ofs = DESC_OFS_FLAGS;
        endcase
        return ofs;
    endfunction

endpackage

// File: rtl/dma_cmd_fetch.sv
// rtl/dma_cmd_fetch.sv - four-word descriptor fetch sequencer
// Purpose: on start_i issues four sequential reads at base_i+0/4/8/C, one
//          outstanding at a time, and flags each returned word with its index.
// Ports:   clk, reset           - clock, async active-high reset
//          start_i, base_i      - begin a fetch at a 16-byte aligned base
//          mem_gnt_i/rvalid_i   - memory handshake inputs
//          req_o, addr_o        - read request and address (stable until gnt)
//          word_vld_o/idx_o     - returned word strobe and its descriptor index
module dma_cmd_fetch
    import dma_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [31:0] base_i,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        req_o,
    output logic [31:0] addr_o,
    output logic        word_vld_o,
    output logic [1:0]  word_idx_o
);

    logic        req_q;
    logic        wait_q;
    logic [1:0]  idx_q;
    logic [31:0] base_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q  <= 1'b0;
            wait_q <= 1'b0;
            idx_q  <= 2'd0;
            base_q <= 32'h0;
        end else if (start_i) begin
            req_q  <= 1'b1;
            wait_q <= 1'b0;
            idx_q  <= 2'd0;
            base_q <= base_i;
        end else if (req_q && mem_gnt_i) begin
            req_q  <= 1'b0;
            wait_q <= 1'b1;
        end else if (wait_q && mem_rvalid_i) begin
            wait_q <= 1'b0;
            if (idx_q != 2'd3) begin
                idx_q <= idx_q + 2'd1;
                req_q <= 1'b1;
            end
        end
    end

    assign req_o      = req_q;
    assign addr_o     = base_q + {28'h0, desc_offset(idx_q)};
    assign word_vld_o = wait_q && mem_rvalid_i;
    assign word_idx_o = idx_q;

endmodule

// File: rtl/dma_ch_ctrl.sv
// rtl/dma_ch_ctrl.sv - single-channel DMA transfer sequencer
// Purpose: copies a buffer word by word (read, then write) over one memory
//          port; reports word and interrupt counters. Optional macro
//          DMA_CMD_LIST_EN enables descriptor chaining via dma_cmd_fetch.
// Ports:   clk, reset                      - clock, async active-high reset
//          ch_start + command inputs       - first command, latched in IDLE
//          mem_req/we/addr/wdata, mem_gnt,
//          mem_rvalid/rdata                - single-master memory port
//          buffer_count, int_count, irq, busy - status back to register file
module dma_ch_ctrl
    import dma_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ch_start,
    input  logic [31:0] rd_start_addr,
    input  logic [31:0] wr_start_addr,
    input  logic [31:0] buffer_size,
    input  logic        set_int,
    input  logic        cmd_last,
    input  logic [27:0] next_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [15:0] buffer_count,
    output logic [15:0] int_count,
    output logic        irq,
    output logic        busy
);

    dma_state_e  state_q;
    logic [31:0] rd_ptr_q;
    logic [31:0] wr_ptr_q;
    logic [29:0] words_q;
    logic        set_int_q;
    logic [15:0] buffer_count_q;
    logic [15:0] int_count_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;   // doubles as the one-word holding register
    logic [1:0]  start_flags;

    assign start_flags[FLAG_SET_INT]  = set_int;
    assign start_flags[FLAG_CMD_LAST] = cmd_last;

`ifdef DMA_CMD_LIST_EN
    logic        cmd_last_q;
    logic [27:0] next_addr_q;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_word_vld;
    logic [1:0]  fetch_idx;
    logic        unused_bits;

    dma_cmd_fetch u_cmd_fetch (
        .clk          (clk),
        .reset        (reset),
        .start_i      ((state_q == CMD_DONE) && !cmd_last_q),
        .base_i       (32'(next_addr_q) << NEXT_ADDR_LSB),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .req_o        (fetch_req),
        .addr_o       (fetch_addr),
        .word_vld_o   (fetch_word_vld),
        .word_idx_o   (fetch_idx)
    );

    // The fetcher owns the read side of the port only while in CMD_RD
    assign mem_req  = (state_q == CMD_RD) ? fetch_req  : mem_req_q;
    assign mem_addr = (state_q == CMD_RD) ? fetch_addr : mem_addr_q;
    assign unused_bits = ^buffer_size[1:0];
`else
    logic unused_bits;

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    // Without chaining every command is the last one
    assign unused_bits = ^{buffer_size[1:0], start_flags[FLAG_CMD_LAST],
                           32'(next_addr) << NEXT_ADDR_LSB};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            rd_ptr_q       <= 32'h0;
            wr_ptr_q       <= 32'h0;
            words_q        <= 30'h0;
            set_int_q      <= 1'b0;
            buffer_count_q <= 16'h0;
            int_count_q    <= 16'h0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 32'h0;
            mem_wdata_q    <= 32'h0;
`ifdef DMA_CMD_LIST_EN
            cmd_last_q     <= 1'b0;
            next_addr_q    <= 28'h0;
`endif
        end else begin
            case (state_q)
                IDLE: if (ch_start) begin
                    rd_ptr_q       <= rd_start_addr;
                    wr_ptr_q       <= wr_start_addr;
                    words_q        <= buffer_size[31:2];
                    set_int_q      <= start_flags[FLAG_SET_INT];
                    buffer_count_q <= 16'h0;
`ifdef DMA_CMD_LIST_EN
                    cmd_last_q     <= start_flags[FLAG_CMD_LAST];
                    next_addr_q    <= next_addr;
`endif
                    if (buffer_size[31:2] == 30'h0) begin
                        state_q <= CMD_DONE;
                    end else begin
                        state_q    <= RD_REQ;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= rd_start_addr;
                    end
                end
                RD_REQ: if (mem_gnt) begin
                    mem_req_q <= 1'b0;
                    state_q   <= RD_WAIT;
                end
                RD_WAIT: if (mem_rvalid) begin
                    mem_wdata_q <= mem_rdata;
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= wr_ptr_q;
                    state_q     <= WR_REQ;
                end
                WR_REQ: if (mem_gnt) begin
                    rd_ptr_q       <= rd_ptr_q + 32'd4;
                    wr_ptr_q       <= wr_ptr_q + 32'd4;
                    buffer_count_q <= buffer_count_q + 16'd1;
                    words_q        <= words_q - 30'd1;
                    mem_we_q       <= 1'b0;
                    if (words_q != 30'd1) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= rd_ptr_q + 32'd4;
                        state_q    <= RD_REQ;
                    end else begin
                        mem_req_q <= 1'b0;
                        state_q   <= CMD_DONE;
                    end
                end
                WR_WAIT: begin
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= rd_ptr_q;
                    state_q    <= RD_REQ;
                end
                CMD_DONE: begin
                    if (set_int_q) begin
                        int_count_q <= int_count_q + 16'd1;
                    end
`ifdef DMA_CMD_LIST_EN
                    state_q <= cmd_last_q ? IDLE : CMD_RD;
`else
                    state_q <= IDLE;
`endif
                end
`ifdef DMA_CMD_LIST_EN
                CMD_RD: if (fetch_word_vld) begin
                    case (fetch_idx)
                        2'd0: rd_ptr_q <= mem_rdata;
                        2'd1: wr_ptr_q <= mem_rdata;
                        2'd2: words_q  <= mem_rdata[31:2];
                        default: begin
                            set_int_q      <= mem_rdata[FLAG_SET_INT];
                            cmd_last_q     <= mem_rdata[FLAG_CMD_LAST];
                            next_addr_q    <= mem_rdata[31:NEXT_ADDR_LSB];
                            buffer_count_q <= 16'h0;
                            if (words_q == 30'h0) begin
                                state_q <= CMD_DONE;
                            end else begin
                                state_q    <= RD_REQ;
                                mem_req_q  <= 1'b1;
                                mem_we_q   <= 1'b0;
                                mem_addr_q <= rd_ptr_q;
                            end
                        end
                    endcase
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_wdata    = mem_wdata_q;
    assign buffer_count = buffer_count_q;
    assign int_count    = int_count_q;
    assign irq          = (state_q == CMD_DONE) && set_int_q;
    assign busy         = (state_q != IDLE);

endmodule
